sys_out_deskew_wr: RTL and testbench
====================================

// Module: sys_out_deskew_wr
// PURPOSE
//  Write-side stage in front of the sys_out DPR. The systolic array emits one result row
//  per wavefront, column c skewed c cycles after column 0. This block realigns each row,
//  packs it into one DPR word and generates the sequential write address. It counts rows
//  and pulses done once a full output tile has been written.
// PARAMETERS
//  DATA_BITS     16  width of one column result
//  N_COLS        4   systolic array columns; DPR word = N_COLS*DATA_BITS
//  FEATURE_BITS  4   DPR address width
//  NUM_ROWS      16  rows per tile, 1..2**FEATURE_BITS
// PORTS
//  sys_clk    in   1                    systolic array clock, all logic on rising edge
//  reset_n    in   1                    asynchronous, active-low reset
//  start      in   1                    begin new tile; sampled in IDLE only
//  col_valid  in   N_COLS               per-column result valid, bit c = column c
//  col_data   in   N_COLS*DATA_BITS     column c at [c*DATA_BITS +: DATA_BITS]
//  dpr_wr_en  out  1                    DPR write strobe
//  dpr_addr   out  FEATURE_BITS         DPR write address
//  dpr_wdata  out  N_COLS*DATA_BITS     aligned row, same column packing as col_data
//  busy       out  1                    high in RUN and DONE
//  done       out  1                    one-cycle pulse after the last row is written
//  err        out  1                    sticky skew error
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, row counter 0, all deskew stages cleared (valid and data).
//  Deskew:
//   - Column c passes through N_COLS-1-c register stages (valid+data). Column N_COLS-1 has
//     zero stages.
//   - The aligned vector then feeds the output registers.
//   - Row whose column c is valid at cycle t0+c: dpr_wr_en=1 at cycle t0+N_COLS.
//   - Delay lines shift every cycle in every state. Writes are gated by state only.
//  FSM:
//   - IDLE: start=1 -> RUN, row counter <= 0, err <= 0. Aligned rows are discarded.
//   - RUN: aligned row with all N_COLS valid bits set -> dpr_wr_en=1, dpr_addr=row counter,
//     dpr_wdata=aligned data. Row counter then increments.
//     - Write with row counter = NUM_ROWS-1 -> DONE.
//     - Aligned vector with some but not all bits set -> no write, err <= 1. Row counter
//       holds; the FSM stays in RUN.
//   - DONE: done=1 for exactly one cycle, no writes, then IDLE.
//  Handshake and boundaries:
//   - start in RUN or DONE is ignored.
//   - Back-to-back rows (a new wavefront every cycle) give one write per cycle with no
//     bubbles.
//   - A row counter >= NUM_ROWS is unreachable. The address never wraps within a tile.
//   - dpr_wr_en is registered and is 0 in every cycle without a write. dpr_addr and
//     dpr_wdata hold their last values when no write occurs.
//   - Rows already in the delay lines when DONE is entered are dropped.
//   - NUM_ROWS=1: the first write goes to address 0, followed by one DONE cycle.
//  Reset mid-operation:
//   - Immediate asynchronous return to the reset state.
//   - In-flight rows are lost. No write occurs after reset_n deasserts until a new start.
//  Width:
//   - No arithmetic on data; pure transport.
//   - Row counter is FEATURE_BITS wide and compared against NUM_ROWS-1.
// TESTING
//  1 Reset: hold reset_n=0 with random inputs -> all outputs 0. Release -> IDLE, no write.
//  2 Single row: start, then col c valid at t0+c with data 16'h10+c (N_COLS=4)
//    -> one write at t0+4, addr 0, wdata {16'h13,16'h12,16'h11,16'h10}.
//  3 Full tile: start, then 16 back-to-back skewed rows with row r data = r
//    -> 16 consecutive writes, addr 0..15. done pulses 1 cycle after the addr-15 write.
//    busy then drops.
//  4 Skew error: column 2 of row 3 arrives one cycle late -> no write for row 3 or the late
//    fragment. err=1 and stays 1. Later good rows write to addr 3, 4, ...
//  5 Ignored inputs: start and valid rows while IDLE-before-start or DONE -> no writes.
//    start pulses mid-RUN do not reset the address.
//  6 Mid-run reset: assert reset_n=0 after the addr-5 write -> outputs 0 at once. A new
//    start then writes from addr 0, and no stale rows appear.

Source files
------------

// File: rtl/sys_out_deskew_wr.sv
// -----------------------------------------------------------------------------
// sys_out_deskew_wr
//
// Write-side stage in front of the sys_out dual-port RAM. The systolic array
// emits one result row per wavefront, with column c arriving c cycles after
// column 0. This block:
//   * realigns each row by delaying column c through N_COLS-1-c register stages,
//   * packs the aligned row into one DPR word,
//   * generates a sequential write address (one per complete row),
//   * flags partially-aligned rows as a sticky skew error,
//   * pulses done once NUM_ROWS rows of a tile have been written.
//
// Interface protocol (valid-only, no backpressure):
//   col_valid[c] qualifies col_data column c in the same cycle. The array
//   cannot be stalled, so there is no ready signal. A row is accepted only when
//   all N_COLS valid bits line up after deskew. dpr_wr_en qualifies
//   dpr_addr/dpr_wdata in the same cycle. dpr_addr/dpr_wdata hold their last
//   value when dpr_wr_en is low.
//
// Ports:
//   sys_clk    in   1                 clock, all logic on rising edge
//   reset_n    in   1                 asynchronous active-low reset
//   start      in   1                 begin a new tile (only honoured in IDLE)
//   col_valid  in   N_COLS            per-column result valid
//   col_data   in   N_COLS*DATA_BITS  column c at [c*DATA_BITS +: DATA_BITS]
//   dpr_wr_en  out  1                 DPR write strobe (registered)
//   dpr_addr   out  FEATURE_BITS      DPR write address
//   dpr_wdata  out  N_COLS*DATA_BITS  aligned row, same packing as col_data
//   busy       out  1                 high while a tile is in progress (RUN/DONE)
//   done       out  1                 one-cycle pulse after the last row write
//   err        out  1                 sticky skew error, cleared by start
//   dbg_state  out  2                 current FSM state, for checkers
// -----------------------------------------------------------------------------
module sys_out_deskew_wr #(
   parameter int DATA_BITS    = 16,
   parameter int N_COLS       = 4,
   parameter int FEATURE_BITS = 4,
   parameter int NUM_ROWS     = 16
) (
   input  logic                          sys_clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [N_COLS-1:0]             col_valid,
   input  logic [N_COLS*DATA_BITS-1:0]   col_data,
   output logic                          dpr_wr_en,
   output logic [FEATURE_BITS-1:0]       dpr_addr,
   output logic [N_COLS*DATA_BITS-1:0]   dpr_wdata,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [1:0]                    dbg_state
);

   localparam logic [FEATURE_BITS-1:0] LAST_ROW = FEATURE_BITS'(NUM_ROWS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [FEATURE_BITS-1:0]       row_q, row_d;
   logic                          err_d;
   logic                          wr_d;

   logic [N_COLS-1:0]             al_valid;
   logic [N_COLS*DATA_BITS-1:0]   al_data;

   // --------------------------------------------------------------------------
   // Deskew delay lines. Column c is delayed N_COLS-1-c cycles so that every
   // column of a wavefront reaches al_valid/al_data in the same cycle as the
   // last (undelayed) column. The lines shift every cycle regardless of state;
   // only the write decision looks at the FSM.
   // --------------------------------------------------------------------------
   for (genvar c = 0; c < N_COLS; c++) begin : g_col
      localparam int DEPTH = N_COLS - 1 - c;

      if (DEPTH == 0) begin : g_pass
         assign al_valid[c]                         = col_valid[c];
         assign al_data[c*DATA_BITS +: DATA_BITS]   = col_data[c*DATA_BITS +: DATA_BITS];
      end else begin : g_dly
         logic [DEPTH-1:0]     v_sr;
         logic [DATA_BITS-1:0] d_sr [DEPTH];

         always_ff @(posedge sys_clk or negedge reset_n) begin
            if (!reset_n) begin
               v_sr <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  d_sr[i] <= '0;
               end
            end else begin
               v_sr[0] <= col_valid[c];
               d_sr[0] <= col_data[c*DATA_BITS +: DATA_BITS];
               for (int i = 1; i < DEPTH; i++) begin
                  v_sr[i] <= v_sr[i-1];
                  d_sr[i] <= d_sr[i-1];
               end
            end
         end

         assign al_valid[c]                       = v_sr[DEPTH-1];
         assign al_data[c*DATA_BITS +: DATA_BITS] = d_sr[DEPTH-1];
      end
   end

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         err     <= err_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next state and write decision
   // A full aligned row in RUN writes at the current row counter. A partial
   // aligned vector (some but not all columns valid) means the skew was
   // violated: nothing is written and the counter holds, so the next good row
   // still lands at the address the bad one would have used.
   // The counter is never incremented past LAST_ROW, so it cannot wrap even
   // when NUM_ROWS == 2**FEATURE_BITS.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      err_d   = err;
      wr_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               row_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (&al_valid) begin
               wr_d = 1'b1;
               if (row_q == LAST_ROW) begin
                  state_d = ST_DONE;
               end else begin
                  row_d = row_q + FEATURE_BITS'(1);
               end
            end else if (|al_valid) begin
               err_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Output registers. done is registered off the DONE state so it pulses in
   // the cycle after the last write strobe.
   // --------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         dpr_wr_en <= 1'b0;
         dpr_addr  <= '0;
         dpr_wdata <= '0;
         done      <= 1'b0;
      end else begin
         dpr_wr_en <= wr_d;
         done      <= (state_q == ST_DONE);
         if (wr_d) begin
            dpr_addr  <= row_q;
            dpr_wdata <= al_data;
         end
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sys_out_deskew_wr.sv
// -----------------------------------------------------------------------------
// tb_sys_out_deskew_wr
//
// Bench for sys_out_deskew_wr. Main instance uses the default geometry
// (4 columns x 16 bits, 16 rows per tile); a second instance with NUM_ROWS=1
// shares the inputs to cover the single-row tile boundary.
// -----------------------------------------------------------------------------
module tb_sys_out_deskew_wr;

   localparam int DB  = 16;
   localparam int NC  = 4;
   localparam int FB  = 4;
   localparam int NR  = 16;
   localparam int W   = NC * DB;
   localparam int TAB = 128;

   localparam int PH_IDLE   = 0;
   localparam int PH_ACTIVE = 1;
   localparam int PH_FINISH = 2;

   // ---------------------------------------------------------------- clock/reset
   logic          sys_clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start   = 1'b0;
   logic [NC-1:0] col_valid = '0;
   logic [W-1:0]  col_data  = '0;

   logic          dpr_wr_en, busy, done, err;
   logic [FB-1:0] dpr_addr;
   logic [W-1:0]  dpr_wdata;
   logic [1:0]    dbg_state;

   logic          wr1, busy1, done1, err1;
   logic [FB-1:0] addr1;
   logic [W-1:0]  wdata1;
   logic [1:0]    dbg_state1;

   always #5 sys_clk = ~sys_clk;

   sys_out_deskew_wr #(
      .DATA_BITS(DB), .N_COLS(NC), .FEATURE_BITS(FB), .NUM_ROWS(NR)
   ) dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .start(start),
      .col_valid(col_valid), .col_data(col_data),
      .dpr_wr_en(dpr_wr_en), .dpr_addr(dpr_addr), .dpr_wdata(dpr_wdata),
      .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
   );

   sys_out_deskew_wr #(
      .DATA_BITS(DB), .N_COLS(NC), .FEATURE_BITS(FB), .NUM_ROWS(1)
   ) dut1 (
      .sys_clk(sys_clk), .reset_n(reset_n), .start(start),
      .col_valid(col_valid), .col_data(col_data),
      .dpr_wr_en(wr1), .dpr_addr(addr1), .dpr_wdata(wdata1),
      .busy(busy1), .done(done1), .err(err1), .dbg_state(dbg_state1)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------------------------------------------------------- stimulus tables
   logic          tab_s [TAB];
   logic [NC-1:0] tab_v [TAB];
   logic [W-1:0]  tab_d [TAB];

   // observed write / done log of the last run (cycle = output cycle index)
   int            wr_cyc_q[$];
   logic [FB-1:0] wr_addr_q[$];
   logic [W-1:0]  wr_data_q[$];
   int            done_cyc_q[$];
   int            wr1_cyc_q[$];
   logic [FB-1:0] wr1_addr_q[$];
   int            done1_cyc_q[$];

   // expected write data scoreboard for a scenario
   logic [W-1:0]  exp_q[$];

   // ---------------------------------------------------------------- reference model
   // Input history (newest last) used to compute what each column looks like
   // after its N-1-c cycle delay.
   logic [NC-1:0] hv_q[$];
   logic [W-1:0]  hd_q[$];

   int            m_phase;
   int            m_rows;
   logic          m_err;
   logic [FB-1:0] m_addr;
   logic [W-1:0]  m_wdata;
   logic          exp_wr, exp_done, exp_busy;

   task automatic model_clear();
      hv_q.delete();
      hd_q.delete();
      m_phase  = PH_IDLE;
      m_rows   = 0;
      m_err    = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      exp_wr   = 1'b0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
   endtask

   // Advance the model by one clock edge given this cycle's start and the
   // deskewed row it sees.
   task automatic model_step(input logic s, input logic [NC-1:0] av, input logic [W-1:0] ad);
      exp_wr   = 1'b0;
      exp_done = (m_phase == PH_FINISH);
      if (m_phase == PH_IDLE) begin
         if (s) begin
            m_phase = PH_ACTIVE;
            m_rows  = 0;
            m_err   = 1'b0;
         end
      end else if (m_phase == PH_ACTIVE) begin
         if (av == {NC{1'b1}}) begin
            exp_wr  = 1'b1;
            m_addr  = FB'(m_rows);
            m_wdata = ad;
            if (m_rows == NR - 1) m_phase = PH_FINISH;
            else                  m_rows  = m_rows + 1;
         end else if (av != '0) begin
            m_err = 1'b1;
         end
      end else begin
         m_phase = PH_IDLE;
      end
      exp_busy = (m_phase != PH_IDLE);
   endtask

   // ---------------------------------------------------------------- driver tasks
   task automatic clear_tab();
      for (int i = 0; i < TAB; i++) begin
         tab_s[i] = 1'b0;
         tab_v[i] = '0;
         tab_d[i] = '0;
      end
      wr_cyc_q.delete();  wr_addr_q.delete(); wr_data_q.delete();
      done_cyc_q.delete();
      wr1_cyc_q.delete(); wr1_addr_q.delete(); done1_cyc_q.delete();
      exp_q.delete();
   endtask

   // Place one skewed row: column c at cycle t0+c (+late for late_col).
   task automatic add_row(input int t0, input logic [W-1:0] word, input int late_col, input int late);
      int t;
      for (int c = 0; c < NC; c++) begin
         t = t0 + c + ((c == late_col) ? late : 0);
         tab_v[t][c]          = 1'b1;
         tab_d[t][c*DB +: DB] = word[c*DB +: DB];
      end
   endtask

   function automatic logic [W-1:0] rand_word();
      logic [W-1:0] w;
      for (int c = 0; c < NC; c++) w[c*DB +: DB] = DB'($urandom);
      return w;
   endfunction

   // Play the table for len cycles, checking every output after each edge
   // against the model. Stops early after a write to stop_addr (if >= 0).
   task automatic run_tab(input int len, input int stop_addr);
      logic [NC-1:0] av;
      logic [W-1:0]  ad;
      int            idx;
      for (int i = 0; i < len; i++) begin
         start     = tab_s[i];
         col_valid = tab_v[i];
         col_data  = tab_d[i];
         hv_q.push_back(tab_v[i]);
         hd_q.push_back(tab_d[i]);
         if (hv_q.size() > NC) begin
            void'(hv_q.pop_front());
            void'(hd_q.pop_front());
         end
         av = '0;
         ad = '0;
         for (int c = 0; c < NC; c++) begin
            idx = hv_q.size() - 1 - (NC - 1 - c);
            if (idx >= 0) begin
               av[c]          = hv_q[idx][c];
               ad[c*DB +: DB] = hd_q[idx][c*DB +: DB];
            end
         end
         model_step(tab_s[i], av, ad);
         @(posedge sys_clk);
         #1;
         n_tests++;
         if (dpr_wr_en !== exp_wr) begin
            n_fail++;
            $display("FAIL wr_en cyc %0d: got %b want %b", i + 1, dpr_wr_en, exp_wr);
         end
         n_tests++;
         if (done !== exp_done) begin
            n_fail++;
            $display("FAIL done cyc %0d: got %b want %b", i + 1, done, exp_done);
         end
         n_tests++;
         if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL busy cyc %0d: got %b want %b", i + 1, busy, exp_busy);
         end
         n_tests++;
         if (err !== m_err) begin
            n_fail++;
            $display("FAIL err cyc %0d: got %b want %b", i + 1, err, m_err);
         end
         n_tests++;
         if (dpr_addr !== m_addr) begin
            n_fail++;
            $display("FAIL addr cyc %0d: got %0d want %0d", i + 1, dpr_addr, m_addr);
         end
         n_tests++;
         if (dpr_wdata !== m_wdata) begin
            n_fail++;
            $display("FAIL wdata cyc %0d: got %h want %h", i + 1, dpr_wdata, m_wdata);
         end
         if (dpr_wr_en === 1'b1) begin
            wr_cyc_q.push_back(i + 1);
            wr_addr_q.push_back(dpr_addr);
            wr_data_q.push_back(dpr_wdata);
         end
         if (done === 1'b1)  done_cyc_q.push_back(i + 1);
         if (wr1 === 1'b1) begin
            wr1_cyc_q.push_back(i + 1);
            wr1_addr_q.push_back(addr1);
         end
         if (done1 === 1'b1) done1_cyc_q.push_back(i + 1);
         if (stop_addr >= 0 && dpr_wr_en === 1'b1 && int'(dpr_addr) == stop_addr) return;
      end
      start     = 1'b0;
      col_valid = '0;
      col_data  = '0;
   endtask

   // Assert reset now (asynchronously), check outputs, hold with random
   // inputs, then release just after a rising edge.
   task automatic do_reset();
      reset_n   = 1'b0;
      start     = 1'($urandom);
      col_valid = NC'($urandom);
      col_data  = rand_word();
      #1;
      n_tests++;
      if ({dpr_wr_en, busy, done, err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got wr/busy/done/err=%b want 0000", {dpr_wr_en, busy, done, err});
      end
      n_tests++;
      if (dpr_addr !== '0 || dpr_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_addr_data: got addr %0d data %h want 0 0", dpr_addr, dpr_wdata);
      end
      n_tests++;
      if ({wr1, busy1, done1, err1} !== 4'b0000 || addr1 !== '0 || wdata1 !== '0) begin
         n_fail++;
         $display("FAIL reset_dut1: got flags %b addr %0d data %h want all 0",
                  {wr1, busy1, done1, err1}, addr1, wdata1);
      end
      repeat (3) begin
         @(posedge sys_clk);
         #1;
         start     = 1'($urandom);
         col_valid = NC'($urandom);
         col_data  = rand_word();
         n_tests++;
         if ({dpr_wr_en, busy, done, err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold: got wr/busy/done/err=%b want 0000", {dpr_wr_en, busy, done, err});
         end
      end
      @(posedge sys_clk);
      #1;
      start     = 1'b0;
      col_valid = '0;
      col_data  = '0;
      reset_n   = 1'b1;
      model_clear();
   endtask

   // ---------------------------------------------------------------- scenarios
   task automatic test_reset();
      do_reset();
      // valid rows with no start must be discarded
      clear_tab();
      add_row(0, rand_word(), -1, 0);
      add_row(1, rand_word(), -1, 0);
      add_row(4, rand_word(), -1, 0);
      run_tab(12, -1);
      n_tests++;
      if (wr_cyc_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_no_write: got %0d writes want 0", wr_cyc_q.size());
      end
   endtask

   task automatic test_single_row();
      logic [W-1:0] w;
      do_reset();
      clear_tab();
      for (int c = 0; c < NC; c++) w[c*DB +: DB] = DB'(16'h10 + c);
      tab_s[0] = 1'b1;
      add_row(1, w, -1, 0);
      run_tab(10, -1);
      n_tests++;
      if (wr_cyc_q.size() != 1) begin
         n_fail++;
         $display("FAIL single_count: got %0d writes want 1", wr_cyc_q.size());
      end else begin
         n_tests++;
         if (wr_cyc_q[0] != 5) begin
            n_fail++;
            $display("FAIL single_latency: got cycle %0d want 5", wr_cyc_q[0]);
         end
         n_tests++;
         if (wr_addr_q[0] !== 4'd0 || wr_data_q[0] !== 64'h0013_0012_0011_0010) begin
            n_fail++;
            $display("FAIL single_word: got addr %0d data %h want 0 0013001200110010",
                     wr_addr_q[0], wr_data_q[0]);
         end
      end
   endtask

   task automatic test_full_tile();
      do_reset();
      clear_tab();
      tab_s[0] = 1'b1;
      for (int r = 0; r < NR; r++) begin
         add_row(r + 1, {NC{DB'(r)}}, -1, 0);
         exp_q.push_back({NC{DB'(r)}});
      end
      run_tab(26, -1);
      n_tests++;
      if (wr_cyc_q.size() != NR) begin
         n_fail++;
         $display("FAIL tile_count: got %0d writes want %0d", wr_cyc_q.size(), NR);
      end else begin
         for (int i = 0; i < NR; i++) begin
            n_tests++;
            if (int'(wr_addr_q[i]) != i || wr_cyc_q[i] != i + 5 || wr_data_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL tile_write%0d: got addr %0d cyc %0d data %h want addr %0d cyc %0d data %h",
                        i, wr_addr_q[i], wr_cyc_q[i], wr_data_q[i], i, i + 5, exp_q[i]);
            end
         end
      end
      n_tests++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != 21) begin
         n_fail++;
         $display("FAIL tile_done: got %0d pulses first at %0d want 1 at 21",
                  done_cyc_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1);
      end
      // NUM_ROWS=1 instance: row 0 at addr 0, then done, then nothing more
      n_tests++;
      if (wr1_cyc_q.size() != 1 || wr1_cyc_q[0] != 5 || wr1_addr_q[0] !== 4'd0) begin
         n_fail++;
         $display("FAIL one_row_write: got %0d writes first cyc %0d want 1 at cyc 5 addr 0",
                  wr1_cyc_q.size(), (wr1_cyc_q.size() > 0) ? wr1_cyc_q[0] : -1);
      end
      n_tests++;
      if (done1_cyc_q.size() != 1 || done1_cyc_q[0] != 6) begin
         n_fail++;
         $display("FAIL one_row_done: got %0d pulses first at %0d want 1 at 6",
                  done1_cyc_q.size(), (done1_cyc_q.size() > 0) ? done1_cyc_q[0] : -1);
      end
   endtask

   task automatic test_skew_error();
      logic [W-1:0] w;
      do_reset();
      clear_tab();
      tab_s[0] = 1'b1;
      for (int r = 0; r < 6; r++) begin
         w = rand_word();
         if (r == 3) add_row(1 + 6 * r, w, 2, 1);
         else begin
            add_row(1 + 6 * r, w, -1, 0);
            exp_q.push_back(w);
         end
      end
      run_tab(42, -1);
      n_tests++;
      if (wr_cyc_q.size() != 5) begin
         n_fail++;
         $display("FAIL skew_count: got %0d writes want 5", wr_cyc_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (int'(wr_addr_q[i]) != i || wr_data_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL skew_write%0d: got addr %0d data %h want addr %0d data %h",
                        i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
            end
         end
      end
      n_tests++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL skew_err_sticky: got %b want 1", err);
      end
   endtask

   task automatic test_ignored();
      do_reset();
      clear_tab();
      // rows before any start, and a row while a tile is completing
      add_row(0, rand_word(), -1, 0);
      add_row(2, rand_word(), -1, 0);
      run_tab(8, -1);
      n_tests++;
      if (wr_cyc_q.size() != 0) begin
         n_fail++;
         $display("FAIL idle_no_write: got %0d writes want 0", wr_cyc_q.size());
      end
      clear_tab();
      tab_s[0]  = 1'b1;
      tab_s[5]  = 1'b1;
      tab_s[9]  = 1'b1;
      tab_s[20] = 1'b1;   // lands in the DONE cycle
      for (int r = 0; r < NR + 3; r++) add_row(r + 1, rand_word(), -1, 0);
      run_tab(30, -1);
      n_tests++;
      if (wr_cyc_q.size() != NR) begin
         n_fail++;
         $display("FAIL ignore_count: got %0d writes want %0d", wr_cyc_q.size(), NR);
      end else begin
         for (int i = 0; i < NR; i++) begin
            n_tests++;
            if (int'(wr_addr_q[i]) != i) begin
               n_fail++;
               $display("FAIL ignore_addr%0d: got %0d want %0d", i, wr_addr_q[i], i);
            end
         end
      end
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_idle_after: got busy %b want 0", busy);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      clear_tab();
      tab_s[0] = 1'b1;
      for (int r = 0; r < 10; r++) add_row(r + 1, rand_word(), -1, 0);
      run_tab(20, 5);
      n_tests++;
      if (wr_addr_q.size() != 6) begin
         n_fail++;
         $display("FAIL midrst_pre: got %0d writes want 6", wr_addr_q.size());
      end
      #2;
      do_reset();
      clear_tab();
      tab_s[0] = 1'b1;
      for (int r = 0; r < 3; r++) begin
         exp_q.push_back(rand_word());
         add_row(r + 2, exp_q[r], -1, 0);
      end
      run_tab(12, -1);
      n_tests++;
      if (wr_cyc_q.size() != 3) begin
         n_fail++;
         $display("FAIL midrst_count: got %0d writes want 3", wr_cyc_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (int'(wr_addr_q[i]) != i || wr_cyc_q[i] != i + 6 || wr_data_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL midrst_write%0d: got addr %0d cyc %0d data %h want addr %0d cyc %0d data %h",
                        i, wr_addr_q[i], wr_cyc_q[i], wr_data_q[i], i, i + 6, exp_q[i]);
            end
         end
      end
   endtask

   // ---------------------------------------------------------------- main / report
   initial begin
      model_clear();
      test_reset();
      test_single_row();
      test_full_tile();
      test_skew_error();
      test_ignored();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
